// File: rtl/key_sched_ctrl_if.sv
// Bus bundle between the AES round-key controller, its expander and the cipher core.
// The controller takes the slave view; the surrounding logic takes the master view.
interface key_sched_ctrl_if #(
    parameter int KEY_S = 128
);
    logic [KEY_S-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic             exp_en;
    logic [KEY_S-1:0] exp_key;
    logic [KEY_S-1:0] exp_round_key;
    logic             exp_w_e;
    logic [3:0]       exp_round_no;
    logic             exp_done;
    logic             cipher_busy;
    logic             rd_en;
    logic [3:0]       rd_addr;
    logic [KEY_S-1:0] rd_data;
    logic             rd_valid;
    logic             keys_ready;
    logic             err;

    modport slave (
        input  key_in, key_valid, exp_round_key, exp_w_e, exp_round_no, exp_done,
               cipher_busy, rd_en, rd_addr,
        output key_ready, exp_en, exp_key, rd_data, rd_valid, keys_ready, err
    );

    modport master (
        output key_in, key_valid, exp_round_key, exp_w_e, exp_round_no, exp_done,
               cipher_busy, rd_en, rd_addr,
        input  key_ready, exp_en, exp_key, rd_data, rd_valid, keys_ready, err
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// Round-key schedule controller: accepts a cipher key, launches one expander run,
// captures the NR+1 round keys and serves registered reads to the cipher core.
module key_sched_ctrl #(
    parameter int KEY_S = 128,
    parameter int NR    = 10
) (
    input logic             clk,
    input logic             reset,
    key_sched_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        READY
    } state_t;

    // The write counter saturates one past a full schedule so a runaway
    // expander can never wrap back onto the "complete" count.
    localparam int                CNT_W    = $clog2(NR + 3);
    localparam logic [3:0]        LAST_IDX = 4'(NR);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NR + 1);
    localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(NR + 2);

    state_t             state_q, state_d;
    logic               key_ready_c;
    logic               accept;
    logic               wr_fire;
    logic               done_fire;
    logic               sched_ok;
    logic               idx_bad_q, idx_bad_now;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_inc;
    logic               rd_fire;
    logic               rd_oob;
    logic [KEY_S-1:0]   exp_key_q;
    logic [KEY_S-1:0]   rd_data_q;
    logic               rd_valid_q;
    logic               keys_ready_q;
    logic               err_q;
    logic [KEY_S-1:0]   store [NR+1];

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        key_ready_c = 1'b0;
        accept      = 1'b0;
        wr_fire     = 1'b0;
        done_fire   = 1'b0;
        wr_cnt_inc  = wr_cnt_q;
        idx_bad_now = idx_bad_q;
        sched_ok    = 1'b0;
        rd_fire     = 1'b0;
        rd_oob      = 1'b0;

        key_ready_c = ((state_q == IDLE) || (state_q == READY)) && !bus.cipher_busy;
        accept      = bus.key_valid && key_ready_c;

        wr_fire   = (state_q == EXPAND) && bus.exp_w_e;
        done_fire = (state_q == EXPAND) && bus.exp_done;
        if (wr_fire) begin
            wr_cnt_inc  = (wr_cnt_q == SAT_CNT) ? SAT_CNT : wr_cnt_q + 1'b1;
            idx_bad_now = idx_bad_q || (bus.exp_round_no > LAST_IDX);
        end
        // The verdict includes the write that lands together with exp_done.
        sched_ok = (wr_cnt_inc == FULL_CNT) && !idx_bad_now;

        rd_fire = (state_q == READY) && bus.rd_en && (bus.rd_addr <= LAST_IDX);
        rd_oob  = (state_q == READY) && bus.rd_en && (bus.rd_addr > LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = EXPAND;
            EXPAND:  if (done_fire) state_d = sched_ok ? READY : IDLE;
            READY:   if (accept) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_key_q    <= '0;
            wr_cnt_q     <= '0;
            idx_bad_q    <= 1'b0;
            keys_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                exp_key_q    <= bus.key_in;
                wr_cnt_q     <= '0;
                idx_bad_q    <= 1'b0;
                keys_ready_q <= 1'b0;
                err_q        <= 1'b0;
            end else if (state_q == EXPAND) begin
                wr_cnt_q  <= wr_cnt_inc;
                idx_bad_q <= idx_bad_now;
                if (done_fire) begin
                    if (sched_ok) keys_ready_q <= 1'b1;
                    else          err_q        <= 1'b1;
                end
            end
            // A bad read address is reported even in the cycle a new key is taken.
            if (rd_oob) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_data_q <= store[bus.rd_addr];
        end
    end

    // NOTE: the key store has no reset; it is unreadable until a complete
    // schedule has been written, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_fire && (bus.exp_round_no <= LAST_IDX)) begin
            store[bus.exp_round_no] <= bus.exp_round_key;
        end
    end

    assign bus.key_ready  = key_ready_c;
    assign bus.exp_en     = (state_q == LOAD);
    assign bus.exp_key    = exp_key_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.err        = err_q;

    a_exp_en_single: assert property (@(posedge clk) disable iff (!reset)
        bus.exp_en |=> !bus.exp_en);
    a_ready_in_ready: assert property (@(posedge clk) disable iff (!reset)
        bus.keys_ready |-> (state_q == READY));
    a_no_accept_busy: assert property (@(posedge clk) disable iff (!reset)
        (state_q inside {LOAD, EXPAND}) |-> !bus.key_ready);

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Controller that owns the round-key expander and the round-key store for the AES datapath. It accepts a new 128-bit cipher key over a valid/ready handshake and launches one expansion run. It captures the 11 round keys into an internal store and then serves registered round-key reads to the cipher core. New keys are held off while the core is mid-block, so the core never sees a partially rewritten schedule.

## Interface
- KEY_S, 128, key and round-key width in bits
- NR, 10, number of AES rounds; the store holds NR+1 entries
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted at 0
- key_in  in  KEY_S  new cipher key
- key_valid  in  1  key_in valid
- key_ready  out  1  controller can accept a key this cycle
- exp_en  out  1  one-cycle launch pulse to the expander
- exp_key  out  KEY_S  key presented to the expander; held from accept until the next accept
- exp_round_key  in  KEY_S  expander output key
- exp_w_e  in  1  expander write strobe
- exp_round_no  in  4  index of exp_round_key
- exp_done  in  1  expander final-round flag; coincides with the last write
- cipher_busy  in  1  core is processing a block with the current schedule
- rd_en  in  1  round-key read request
- rd_addr  in  4  round index, 0..NR
- rd_data  out  KEY_S  registered read data
- rd_valid  out  1  rd_data valid
- keys_ready  out  1  complete schedule present in the store
- err  out  1  sticky error flag

## Operation
- States: IDLE (no valid schedule), LOAD, EXPAND, READY.
- Handshake: key_ready = (state is IDLE or READY) and !cipher_busy. A key is accepted on the edge where key_valid and key_ready are both 1.
- On accept:
  - key_in is latched into exp_key.
  - keys_ready and err clear.
  - The write counter resets to 0.
  - State moves to LOAD.
- LOAD: exp_en = 1 for exactly this cycle. State moves to EXPAND.
- EXPAND:
  - Each exp_w_e writes store[exp_round_no] <= exp_round_key and increments the write counter.
  - On exp_done, state moves to READY if the counter including this write equals NR+1 and every exp_round_no was ≤ NR. keys_ready is set.
  - Otherwise err sets and state returns to IDLE.
- exp_w_e or exp_done outside EXPAND is ignored: no store write, no state change.
- Reads are served only in READY. rd_en with rd_addr ≤ NR gives rd_data = store[rd_addr] and rd_valid = 1 on the next cycle.
- rd_en with rd_addr > NR: rd_valid stays 0, rd_data holds, err sets (sticky).
- rd_en outside READY: rd_valid stays 0, rd_data holds, no error.
- Accept and read in the same cycle while in READY: the read is served from the old schedule. The store is not written before the first exp_w_e.
- cipher_busy does not gate reads. It only blocks key acceptance.

## Timing
- Reset values:
  - state IDLE
  - key_ready = !cipher_busy (combinational)
  - exp_en 0, exp_key 0
  - rd_data 0, rd_valid 0
  - keys_ready 0, err 0
  - store contents don't-care, never readable before a complete schedule
- Accept at edge E0:
  - exp_en is high from E0 to E1.
  - The expander writes round 0 at E2 and rounds 1..NR at E3..E(NR+2); exp_done arrives with round NR.
  - keys_ready rises after E(NR+2), i.e. 12 cycles after accept for NR=10.
- Read latency: 1 cycle. rd_valid is a 1-cycle pulse per request; back-to-back requests give back-to-back data.
- Throughput: one key per NR+3 cycles minimum. key_ready is 0 in LOAD and EXPAND.
- Reset asserted mid-expansion: returns to IDLE immediately and keys_ready drops. The expander is reset from the same source.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c accepted with cipher_busy=0:
  - exp_en pulses once.
  - keys_ready rises 12 cycles after accept.
  - rd_addr 0 returns the key.
  - rd_addr 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle after rd_en.
- cipher_busy=1 in READY with key_valid=1:
  - key_ready=0 and no exp_en; reads still return the old keys.
  - Drop cipher_busy: the key is accepted on that edge.
- Key 000102030405060708090a0b0c0d0e0f:
  - rd_addr 10 returns 13111d7fe3944a17f307a78b4d2b30c5.
  - Same-cycle accept and read of addr 10 still returns the previous round-10 key.
- Bad accesses:
  - rd_addr 11 in READY: rd_valid 0, err 1.
  - rd_en during EXPAND: rd_valid 0, err unchanged.
  - Next key accept clears err.
- Faulty expander model asserts exp_done after 5 writes: err=1, state IDLE, keys_ready 0, key_ready 1.
- Reset pulse at the 4th expansion cycle, then release: all outputs at reset values. A fresh key accept completes normally.
